predsub: RTL and testbench



---
 rtl/intra_pkg.sv | 42 ++++
 rtl/predsub_sad_row16.sv | 37 +++
 rtl/predsub.sv | 195 +++++++++++++++++++
 tb/tb_predsub.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/intra_pkg.sv
// Shared definitions for the intra prediction blocks (encoder-side predsub
// and the matching decoder adder).
//   - MB geometry constants
//   - intra mode encoding (must stay identical between adder and predsub)
//   - predsub control FSM states
//   - pred_pix: per-pixel predictor for a given mode
package intra_pkg;

  localparam int MB_L   = 16;
  localparam int MB_W   = 16;
  localparam int MB_PIX = MB_L * MB_W;

  typedef enum logic [2:0] {
    MODE_VERT = 3'd0,
    MODE_HORZ = 3'd1,
    MODE_DC   = 3'd2
  } mode_e;

  // ST_LOAD is kept so the encoding lines up with the adder's FSM; the
  // block captures its inputs on the accepting edge, so it is never entered.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DCSUM = 3'd2,
    ST_EVAL  = 3'd3,
    ST_EMIT  = 3'd4
  } state_e;

  // Predicted pixel: Vertical uses the pixel above the column, Horizontal the
  // pixel left of the row, anything else the DC value.
  function automatic logic [7:0] pred_pix(input logic [1:0] m,
                                          input logic [7:0] top_px,
                                          input logic [7:0] left_px,
                                          input logic [7:0] dc);
    case (m)
      2'd0:    return top_px;
      2'd1:    return left_px;
      default: return dc;
    endcase
  endfunction

endpackage

// File: rtl/predsub_sad_row16.sv
// sad_row16: combinational SAD of one 16-pixel row.
//   orig_i [15:0][7:0] : original pixels
//   pred_i [15:0][7:0] : predicted pixels
//   sad_o  [11:0]      : sum of |orig - pred| (max 16*255 = 4080)
// Absolute differences feed a balanced 4-level adder tree that grows one bit
// per level, so no stage can overflow.
module sad_row16 (
  input  logic [15:0][7:0] orig_i,
  input  logic [15:0][7:0] pred_i,
  output logic [11:0]      sad_o
);

  logic [15:0][7:0] ad;
  logic [7:0][8:0]  s1;
  logic [3:0][9:0]  s2;
  logic [1:0][10:0] s3;

  for (genvar i = 0; i < 16; i++) begin : g_ad
    assign ad[i] = (orig_i[i] >= pred_i[i]) ? (orig_i[i] - pred_i[i])
                                            : (pred_i[i] - orig_i[i]);
  end

  for (genvar i = 0; i < 8; i++) begin : g_s1
    assign s1[i] = {1'b0, ad[2*i]} + {1'b0, ad[2*i+1]};
  end

  for (genvar i = 0; i < 4; i++) begin : g_s2
    assign s2[i] = {1'b0, s1[2*i]} + {1'b0, s1[2*i+1]};
  end

  for (genvar i = 0; i < 2; i++) begin : g_s3
    assign s3[i] = {1'b0, s2[2*i]} + {1'b0, s2[2*i+1]};
  end

  assign sad_o = {1'b0, s3[0]} + {1'b0, s3[1]};

endmodule

// File: rtl/predsub.sv
// predsub: intra mode decision + residue generation for one 16x16 luma MB.
// Evaluates Vertical, Horizontal and DC predictors one row per cycle,
// keeps the lowest-SAD mode (lower mode wins ties) and emits
// residue = (original - prediction) mod 256 for the chosen mode.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   start               : request, only looked at while idle
//   original[256]       : source MB, raster order (row*16 + col)
//   toppixels[16]       : row above the MB, by column
//   leftpixels[16]      : column left of the MB, by row
//   busy                : operation in flight
//   done                : one-cycle pulse, results valid from this cycle
//   mode, sad, residue  : selected mode, its SAD, residue block (held)
// Timing: accept at edge N, DC at N+1, 48 row evaluations at N+2..N+49,
// results registered at N+50.
module predsub
  import intra_pkg::*;
#(
  parameter int MB_SIZE_L = 16,
  parameter int MB_SIZE_W = 16,
  parameter int NUM_MODES = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic [MB_SIZE_L*MB_SIZE_W-1:0][7:0]   original,
  input  logic [MB_SIZE_W-1:0][7:0]             toppixels,
  input  logic [MB_SIZE_L-1:0][7:0]             leftpixels,
  output logic                                  busy,
  output logic                                  done,
  output logic [2:0]                            mode,
  output logic [15:0]                           sad,
  output logic [MB_SIZE_L*MB_SIZE_W-1:0][7:0]   residue
);

  state_e               state_q, state_d;
  logic [MB_PIX-1:0][7:0] orig_q, orig_d;
  logic [MB_W-1:0][7:0] top_q, top_d;
  logic [MB_L-1:0][7:0] left_q, left_d;
  logic [7:0]           dc_q, dc_d;
  logic [3:0]           r_q, r_d;
  logic [1:0]           m_q, m_d;
  logic [15:0]          acc_q, acc_d;
  logic [15:0]          best_sad_q, best_sad_d;
  logic [1:0]           best_mode_q, best_mode_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [2:0]           mode_q, mode_d;
  logic [15:0]          sad_q, sad_d;
  logic [MB_PIX-1:0][7:0] res_q, res_d;

  logic [12:0]          dc_sum;
  logic [15:0][7:0]     orig_row, pred_row;
  logic [11:0]          row_sad;
  logic [15:0]          sad_fin;
  logic [MB_PIX-1:0][7:0] res_calc;

  // DC = (sum of 32 neighbours) >> 5, truncating to match the adder.
  always_comb begin
    dc_sum = '0;
    for (int i = 0; i < 16; i++) begin
      dc_sum = dc_sum + 13'(top_q[i]) + 13'(left_q[i]);
    end
  end

  // Row r of mode m: original row and predictor row side by side.
  always_comb begin
    for (int c = 0; c < 16; c++) begin
      orig_row[c] = orig_q[{r_q, 4'(c)}];
      pred_row[c] = pred_pix(m_q, top_q[c], left_q[r_q], dc_q);
    end
  end

  sad_row16 u_sad_row (
    .orig_i (orig_row),
    .pred_i (pred_row),
    .sad_o  (row_sad)
  );

  assign sad_fin = acc_q + {4'd0, row_sad};

  // Residue for the winning mode; 8-bit wrap so the adder undoes it exactly.
  for (genvar k = 0; k < MB_PIX; k++) begin : g_res
    assign res_calc[k] = orig_q[k] - pred_pix(best_mode_q, top_q[k % 16],
                                              left_q[k / 16], dc_q);
  end

  always_comb begin
    state_d     = state_q;
    orig_d      = orig_q;
    top_d       = top_q;
    left_d      = left_q;
    dc_d        = dc_q;
    r_d         = r_q;
    m_d         = m_q;
    acc_d       = acc_q;
    best_sad_d  = best_sad_q;
    best_mode_d = best_mode_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    mode_d      = mode_q;
    sad_d       = sad_q;
    res_d       = res_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          orig_d  = original;
          top_d   = toppixels;
          left_d  = leftpixels;
          busy_d  = 1'b1;
          state_d = ST_DCSUM;
        end
      end
      ST_LOAD: state_d = ST_DCSUM;
      ST_DCSUM: begin
        dc_d        = dc_sum[12:5];
        r_d         = '0;
        m_d         = '0;
        acc_d       = '0;
        best_sad_d  = 16'hFFFF;
        best_mode_d = '0;
        state_d     = ST_EVAL;
      end
      ST_EVAL: begin
        if (r_q == 4'd15) begin
          // Strict less-than: modes run in ascending order, so ties keep
          // the lower mode.
          if (sad_fin < best_sad_q) begin
            best_sad_d  = sad_fin;
            best_mode_d = m_q;
          end
          acc_d = '0;
          r_d   = '0;
          m_d   = m_q + 2'd1;
          if (m_q == 2'(NUM_MODES - 1)) state_d = ST_EMIT;
        end else begin
          acc_d = sad_fin;
          r_d   = r_q + 4'd1;
        end
      end
      ST_EMIT: begin
        res_d   = res_calc;
        mode_d  = {1'b0, best_mode_q};
        sad_d   = best_sad_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      orig_q      <= '0;
      top_q       <= '0;
      left_q      <= '0;
      dc_q        <= '0;
      r_q         <= '0;
      m_q         <= '0;
      acc_q       <= '0;
      best_sad_q  <= '0;
      best_mode_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mode_q      <= '0;
      sad_q       <= '0;
      res_q       <= '0;
    end else begin
      state_q     <= state_d;
      orig_q      <= orig_d;
      top_q       <= top_d;
      left_q      <= left_d;
      dc_q        <= dc_d;
      r_q         <= r_d;
      m_q         <= m_d;
      acc_q       <= acc_d;
      best_sad_q  <= best_sad_d;
      best_mode_q <= best_mode_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      mode_q      <= mode_d;
      sad_q       <= sad_d;
      res_q       <= res_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign mode    = mode_q;
  assign sad     = sad_q;
  assign residue = res_q;

endmodule

// File: tb/tb_predsub.sv
// Bench for predsub: a table of hand-derived vectors plus model-checked
// random blocks, compared through an expected-result queue when done fires,
// followed by protocol sequences (held start, start while busy, reset abort).
module tb_predsub;

  logic              clk = 1'b0;
  logic              reset, start;
  logic [255:0][7:0] original, residue;
  logic [15:0][7:0]  toppixels, leftpixels;
  logic              busy, done;
  logic [2:0]        mode;
  logic [15:0]       sad;

  predsub dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .original   (original),
    .toppixels  (toppixels),
    .leftpixels (leftpixels),
    .busy       (busy),
    .done       (done),
    .mode       (mode),
    .sad        (sad),
    .residue    (residue)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0][7:0]  top;
    logic [15:0][7:0]  left;
    logic [255:0][7:0] orig;
    logic [2:0]        mode;
    logic [15:0]       sad;
    logic [255:0][7:0] res;
  } vec_t;

  vec_t tbl [5];
  vec_t sb [$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_res(input string nm, input logic [255:0][7:0] exp);
    int bad;
    bad = -1;
    n_cmp++;
    for (int k = 255; k >= 0; k--) if (residue[k] !== exp[k]) bad = k;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s: residue[%0d] got %0h, expected %0h", nm, bad, residue[bad], exp[bad]);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] t, input logic [7:0] l, input logic [7:0] o,
                              input logic [2:0] m, input logic [15:0] s, input logic [7:0] r);
    vec_t v;
    for (int i = 0; i < 16; i++) begin v.top[i] = t; v.left[i] = l; end
    for (int k = 0; k < 256; k++) begin v.orig[k] = o; v.res[k] = r; end
    v.mode = m;
    v.sad  = s;
    return v;
  endfunction

  // Reference: straightforward per-mode SAD, first minimum wins.
  function automatic vec_t model(input logic [15:0][7:0] t, input logic [15:0][7:0] l,
                                 input logic [255:0][7:0] o);
    vec_t e;
    int s [3];
    int dcs, bm, d;
    logic [7:0] dc, p;
    e.top = t; e.left = l; e.orig = o;
    dcs = 0;
    for (int i = 0; i < 16; i++) dcs += int'(t[i]) + int'(l[i]);
    dc = 8'(dcs / 32);
    for (int m = 0; m < 3; m++) begin
      s[m] = 0;
      for (int rr = 0; rr < 16; rr++)
        for (int cc = 0; cc < 16; cc++) begin
          p = (m == 0) ? t[cc] : (m == 1) ? l[rr] : dc;
          d = int'(o[rr*16+cc]) - int'(p);
          s[m] += (d < 0) ? -d : d;
        end
    end
    bm = 0;
    for (int m = 1; m < 3; m++) if (s[m] < s[bm]) bm = m;
    e.mode = 3'(bm);
    e.sad  = 16'(s[bm]);
    for (int k = 0; k < 256; k++) begin
      p = (bm == 0) ? t[k % 16] : (bm == 1) ? l[k / 16] : dc;
      e.res[k] = o[k] - p;
    end
    return e;
  endfunction

  task automatic scramble();
    for (int k = 0; k < 256; k++) original[k] = 8'($urandom);
    for (int i = 0; i < 16; i++) begin
      toppixels[i]  = 8'($urandom);
      leftpixels[i] = 8'($urandom);
    end
  endtask

  // One MB: drive, push expectation, scramble inputs after accept, wait done.
  task automatic run_vec(input vec_t v, input string nm);
    int   cyc;
    vec_t e;
    @(negedge clk);
    toppixels  = v.top;
    leftpixels = v.left;
    original   = v.orig;
    start      = 1'b1;
    sb.push_back(v);
    @(posedge clk);
    #1 start = 1'b0;
    scramble();
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({nm, "_busy"}, 32'(busy), 1);
    end while (!done && cyc < 200);
    check({nm, "_latency"}, cyc, 51);
    e = sb.pop_front();
    if (done) begin
      check({nm, "_busy_at_done"}, 32'(busy), 0);
      check({nm, "_mode"}, 32'(mode), 32'(e.mode));
      check({nm, "_sad"}, 32'(sad), 32'(e.sad));
      check_res({nm, "_res"}, e.res);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int   cyc, nd, d1, d2;
    vec_t v;

    tbl[0] = mk(100, 50, 100, 3'd0, 16'd0, 8'h00);
    tbl[1] = mk(0, 200, 200, 3'd1, 16'd0, 8'h00);
    for (int i = 0; i < 16; i++) tbl[1].top[i] = 8'(i);
    tbl[2] = mk(40, 60, 50, 3'd2, 16'd0, 8'h00);
    tbl[3] = mk(0, 0, 0, 3'd0, 16'd255, 8'h00);
    tbl[3].orig[0] = 8'd255;
    tbl[3].res[0]  = 8'hFF;
    tbl[4] = mk(10, 20, 0, 3'd0, 16'd2560, 8'hF6);

    reset = 1'b1; start = 1'b0;
    original = '0; toppixels = '0; leftpixels = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_mode", 32'(mode), 0);
    check("rst_sad", 32'(sad), 0);
    check("rst_res_nz", 32'(residue != '0), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(tbl[i], $sformatf("tbl%0d", i));

    for (int n = 0; n < 4; n++) begin
      for (int i = 0; i < 16; i++) begin
        v.top[i]  = 8'($urandom);
        v.left[i] = 8'($urandom);
      end
      for (int k = 0; k < 256; k++)
        case (n)
          1:       v.orig[k] = v.left[k / 16] + 8'($urandom_range(0, 6));
          2:       v.orig[k] = v.top[k % 16] - 8'($urandom_range(0, 6));
          default: v.orig[k] = 8'($urandom);
        endcase
      run_vec(model(v.top, v.left, v.orig), $sformatf("rnd%0d", n));
    end

    // Held start: accepts back-to-back, done every 51 cycles.
    @(negedge clk);
    toppixels = tbl[4].top; leftpixels = tbl[4].left; original = tbl[4].orig;
    start = 1'b1;
    nd = 0; d1 = -1; d2 = -1;
    for (cyc = 1; cyc <= 110; cyc++) begin
      @(negedge clk);
      if (done) begin
        nd++;
        if (nd == 1) d1 = cyc;
        if (nd == 2) begin
          d2 = cyc;
          check("hold_sad2", 32'(sad), 2560);
        end
      end
    end
    start = 1'b0;
    check("hold_ndone", nd, 2);
    check("hold_done1", d1, 51);
    check("hold_done2", d2, 102);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Start pulse while busy is dropped.
    start = 1'b1;
    nd = 0; d1 = -1;
    for (cyc = 1; cyc <= 120; cyc++) begin
      @(negedge clk);
      start = (cyc == 10);
      if (done) begin
        nd++;
        if (nd == 1) d1 = cyc;
      end
    end
    start = 1'b0;
    check("busy_start_ndone", nd, 1);
    check("busy_start_done1", d1, 51);

    // Reset in the middle of EVAL aborts with no done.
    start = 1'b1;
    for (cyc = 1; cyc <= 21; cyc++) begin
      @(negedge clk);
      start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_mode", 32'(mode), 0);
    check("abort_sad", 32'(sad), 0);
    check("abort_res_nz", 32'(residue != '0), 0);
    reset = 1'b0;
    nd = 0;
    for (cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("abort_no_done", nd, 0);

    run_vec(tbl[2], "after_abort");

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
